clk_period_monitor: RTL and testbench

//  Receive-side partner of the team's clock divider: samples a slow square wave
//  (divided clock or any external low-rate signal) in the fast clk domain.

---
 rtl/clk_period_monitor.sv | 130 +++++++++++++
 tb/tb_clk_period_monitor.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// Slow-signal period monitor: synchronizes in_sig into clk, emits rising-edge ticks,
// measures edge-to-edge period, and qualifies lock / loss of the monitored signal.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_FIRST | no reference edge yet; next edge starts the first measurement
// MEASURE    | reference edge seen; each edge closes a period and restarts
// LOST       | TIMEOUT cycles without an edge; next edge restarts measuring
module clk_period_monitor #(
   parameter int unsigned W          = 32,
   parameter int unsigned EXPECTED   = 20000000,
   parameter int unsigned TOL        = 1000,
   parameter int unsigned TIMEOUT    = 40000000,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_sig,
   output logic         tick,
   output logic [W-1:0] period,
   output logic         period_valid,
   output logic         locked,
   output logic         lost
);

   localparam logic [1:0] WAIT_FIRST = 2'd0;
   localparam logic [1:0] MEASURE    = 2'd1;
   localparam logic [1:0] LOST       = 2'd2;

   localparam int unsigned GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

   localparam logic [W-1:0]  LO_LIM   = W'(EXPECTED - TOL);
   localparam logic [W-1:0]  HI_LIM   = W'(EXPECTED + TOL);
   localparam logic [W-1:0]  CNT_MAX  = W'(TIMEOUT - 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);

   logic          sync1, sync2, sync3;
   logic          rise;
   logic [W-1:0]  cnt;
   logic [W-1:0]  cnt_inc;
   logic          cnt_term;
   logic          in_range;
   logic [1:0]    state;
   logic [GW-1:0] good_cnt;
   logic [GW-1:0] good_inc;

   assign rise     = sync2 & ~sync3;
   assign cnt_inc  = cnt + W'(1);
   assign cnt_term = (cnt == CNT_MAX);
   // cnt_inc is the period length when this cycle carries the closing edge
   assign in_range = (cnt_inc >= LO_LIM) && (cnt_inc <= HI_LIM);

   always_comb begin
      good_inc = good_cnt;
      if (good_cnt != GOOD_MAX) begin
         good_inc = good_cnt + GW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         sync3        <= 1'b0;
         cnt          <= '0;
         good_cnt     <= '0;
         state        <= WAIT_FIRST;
         tick         <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         lost         <= 1'b0;
      end else begin
         sync1        <= in_sig;
         sync2        <= sync1;
         sync3        <= sync2;
         tick         <= rise;
         period_valid <= 1'b0;

         // timer saturates at terminal count so it never wraps while lost
         if (rise) begin
            cnt <= '0;
         end else if (!cnt_term) begin
            cnt <= cnt_inc;
         end

         case (state)
            WAIT_FIRST: begin
               if (rise) begin
                  state <= MEASURE;
               end else if (cnt_term) begin
                  state    <= LOST;
                  lost     <= 1'b1;
                  locked   <= 1'b0;
                  good_cnt <= '0;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period       <= cnt_inc;
                  period_valid <= 1'b1;
                  if (in_range) begin
                     good_cnt <= good_inc;
                     locked   <= (good_inc == GOOD_MAX);
                  end else begin
                     good_cnt <= '0;
                     locked   <= 1'b0;
                  end
               end else if (cnt_term) begin
                  state    <= LOST;
                  lost     <= 1'b1;
                  locked   <= 1'b0;
                  good_cnt <= '0;
               end
            end
            LOST: begin
               // restart edge only re-arms; the period it closes is meaningless
               if (rise) begin
                  state <= MEASURE;
                  lost  <= 1'b0;
               end
            end
            default: begin
               state <= WAIT_FIRST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor with EXPECTED=20, TOL=1, TIMEOUT=40, LOCK_COUNT=2.
module tb_clk_period_monitor;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         in_sig;
   logic         tick;
   logic [W-1:0] period;
   logic         period_valid;
   logic         locked;
   logic         lost;

   int n_checks = 0;
   int n_errors = 0;

   clk_period_monitor #(
      .W          (W),
      .EXPECTED   (20),
      .TOL        (1),
      .TIMEOUT    (40),
      .LOCK_COUNT (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_sig       (in_sig),
      .tick         (tick),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .lost         (lost)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a falling clk edge. Raises in_sig for hi cycles, lowers it for lo
   // cycles; the rise is seen on tick at the third falling edge after it is driven.
   task automatic rise_period(input string tag, input int hi, input int lo,
                              input logic exp_pv, input int exp_per, input logic exp_lock);
      in_sig = 1'b1;
      for (int k = 1; k <= hi + lo; k++) begin
         @(negedge clk);
         if (k == hi) in_sig = 1'b0;
         if (k == 3) begin
            check_eq({tag, ".tick"},   tick,         1);
            check_eq({tag, ".pv"},     period_valid, exp_pv);
            check_eq({tag, ".period"}, period,       exp_per);
            check_eq({tag, ".locked"}, locked,       exp_lock);
            check_eq({tag, ".lost"},   lost,         0);
         end else begin
            check_eq({tag, ".tick0"},  tick,         0);
            check_eq({tag, ".pv0"},    period_valid, 0);
         end
      end
   endtask

   initial begin
      rst    = 1'b0;
      in_sig = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst.tick",   tick,         0);
      check_eq("rst.period", period,       0);
      check_eq("rst.pv",     period_valid, 0);
      check_eq("rst.locked", locked,       0);
      check_eq("rst.lost",   lost,         0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // nominal 20-cycle periods, lock on the second valid period
      rise_period("p1",  10, 10, 0, 0,  0);
      rise_period("p2",  10, 10, 1, 20, 0);
      rise_period("p3",  10, 10, 1, 20, 1);
      // one long period breaks lock, two good ones restore it
      rise_period("p4",  12, 13, 1, 20, 1);
      rise_period("p5",  10, 10, 1, 25, 0);
      rise_period("p6",  10, 10, 1, 20, 0);
      // tolerance edges 19 and 21 keep lock, 18 drops it
      rise_period("p7",  10,  9, 1, 20, 1);
      rise_period("p8",  10, 11, 1, 19, 1);
      rise_period("p9",   9,  9, 1, 21, 1);
      rise_period("p10", 10, 10, 1, 18, 0);
      rise_period("p11", 10, 10, 1, 20, 0);
      rise_period("p12", 10, 10, 1, 20, 1);

      // last edge then silence: lost at the 43rd falling edge after driving the rise
      rise_period("p13", 10, 10, 1, 20, 1);
      repeat (22) @(negedge clk);
      check_eq("to.lost_early", lost,   0);
      check_eq("to.lock_early", locked, 1);
      @(negedge clk);
      check_eq("to.lost",   lost,   1);
      check_eq("to.locked", locked, 0);
      repeat (10) @(negedge clk);
      check_eq("to.lost_hold", lost,   1);
      check_eq("to.period",    period, 20);

      rise_period("p14", 10, 10, 0, 20, 0);
      rise_period("p15", 10, 10, 1, 20, 0);
      rise_period("p16", 10, 10, 1, 20, 1);

      // one-cycle pulse, then a long high level that must not retrigger
      rise_period("p17",  1, 19, 1, 20, 1);
      rise_period("p18", 15,  5, 1, 20, 1);

      // asynchronous reset in the middle of a measurement
      in_sig = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("mr.pre_period", period, 20);
      check_eq("mr.pre_locked", locked, 1);
      #2;
      rst    = 1'b0;
      in_sig = 1'b0;
      #1;
      check_eq("mr.tick",   tick,         0);
      check_eq("mr.period", period,       0);
      check_eq("mr.pv",     period_valid, 0);
      check_eq("mr.locked", locked,       0);
      check_eq("mr.lost",   lost,         0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rise_period("p20", 10, 10, 0, 0,  0);
      rise_period("p21", 10, 10, 1, 20, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
